// File: rtl/slice_loader_pkg.sv
// Shared constants and state encoding for the slice loader.
package slice_loader_pkg;

    // Bits per 5x5 slice; fixed by the parity stage input width.
    localparam int WIDTH     = 25;
    // Enough bits to count 0..WIDTH-1.
    localparam int BIT_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/slice_loader_bounded_counter.sv
// Up-counter from 0 to MAX with synchronous clear and a terminal-count flag.
// It saturates at MAX instead of wrapping, so a stray enable at the
// terminal value cannot roll the count over.
module slice_loader_bounded_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign tc = (cnt == MAX_V);

    // Count register: clear wins over enable, hold at MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/slice_loader.sv
// Serial-to-parallel loader: assembles 25-bit slices one bit per cycle and
// hands each to the parity stage over a valid/ready handshake, NUM_SLICES
// slices per load operation.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_LOAD    | accepting serial bits into the slice register
// ST_PRESENT | full slice on out, waiting for outReady
// ST_DONE    | one-cycle completion pulse, then back to idle
module slice_loader
    import slice_loader_pkg::*;
#(
    parameter int NUM_SLICES = 64,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             serIn,
    input  logic             serValid,
    output logic             serReady,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic             outValid,
    output logic [IDX_W-1:0] sliceIdx,
    output logic             busy,
    output logic             done
);

    state_t               state;
    state_t               state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_pos;
    logic                 bit_tc;
    logic [IDX_W-1:0]     slice_cnt;
    logic                 slice_tc;
    logic                 accept;
    logic                 handshake;
    logic                 launch;

    assign accept    = (state == ST_LOAD) && serValid;
    assign handshake = (state == ST_PRESENT) && outReady;
    assign launch    = (state == ST_IDLE) && start;

    // First accepted bit lands in the MSB (row 0 / column 0).
    assign bit_pos  = BIT_CNT_W'(WIDTH - 1) - bit_cnt;
    assign sliceIdx = slice_cnt;

    slice_loader_bounded_counter #(
        .MAX (WIDTH - 1),
        .W   (BIT_CNT_W)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .clr (launch || handshake),
        .cnt (bit_cnt),
        .tc  (bit_tc)
    );

    // The last slice's handshake goes to DONE, so the slice count is never
    // bumped past NUM_SLICES-1.
    slice_loader_bounded_counter #(
        .MAX (NUM_SLICES - 1),
        .W   (IDX_W)
    ) u_slice_cnt (
        .clk (clk),
        .rst (rst),
        .en  (handshake && !slice_tc),
        .clr (launch),
        .cnt (slice_cnt),
        .tc  (slice_tc)
    );

    // Slice register: only written by accepted bits in LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (accept) begin
            out[bit_pos] <= serIn;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs decoded from the registered state.
    always_comb begin
        state_nxt = state;
        serReady  = 1'b0;
        outValid  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                serReady = 1'b1;
                if (accept && bit_tc) begin
                    state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                outValid = 1'b1;
                if (outReady) begin
                    state_nxt = slice_tc ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/slice_loader.md
Name: slice_loader

Overview:
- Serial-to-parallel front end for the column-parity (theta) stage.
- Collects one 25-bit 5x5 slice one bit per cycle from a serial source, then presents it as a stable parallel word with a valid/ready handshake.
- Iterates over NUM_SLICES slices per load operation, then signals completion to the round controller.
- Output index 24 is row 0 / column 0 of the slice; index 0 is row 4 / column 4, matching the parity stage's bit ordering.

Parameters:
- WIDTH, 25, bits per slice (5x5); fixed by the parity stage, not to be overridden.
- NUM_SLICES, 64, slices per load operation (lane depth); legal range 1..64.
- IDX_W, 6, width of slice index; must satisfy 2^IDX_W >= NUM_SLICES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load operation; sampled only in IDLE.
- serIn  in  1  serial data bit.
- serValid  in  1  serIn is valid this cycle.
- serReady  out  1  loader accepts serial bits; high only in LOAD.
- outReady  in  1  downstream accepts parallel slice.
- out  out  WIDTH  assembled slice, feeds the parity stage input.
- outValid  out  1  out holds a complete slice.
- sliceIdx  out  IDX_W  index of the slice currently loading or presented.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last slice handshake.

Behaviour:
- Reset values:
  - State = IDLE; shift register, bitCnt and sliceCnt = 0.
  - out = 0; outValid, serReady, busy, done = 0; sliceIdx = 0.
  - Reset is asynchronous and takes effect mid-operation. Any partial slice is discarded, with no done pulse.
- State machine (registered, one-hot or binary; encoding from the package):
  - IDLE: if start=1, go to LOAD with bitCnt=0 and sliceCnt=0. Otherwise stay.
  - LOAD:
    - serReady=1.
    - Each cycle with serValid=1, write serIn into bit position (WIDTH-1-bitCnt) and increment bitCnt. The first accepted bit lands in out[24]; the 25th lands in out[0].
    - Cycles with serValid=0 stall with no change.
    - On the accept where bitCnt==WIDTH-1, go to PRESENT next cycle.
  - PRESENT:
    - outValid=1; out is stable and serReady=0. serIn and serValid are ignored.
    - On outReady=1 (handshake completes that cycle):
      - If sliceCnt==NUM_SLICES-1, go to DONE.
      - Otherwise increment sliceCnt, clear bitCnt and go to LOAD.
    - outReady=0 holds indefinitely with no timeout.
  - DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 here.
- Latency:
  - First slice: outValid rises the cycle after the 25th accepted bit. With continuous serValid, that is 26 cycles after the start-sample edge.
  - Back-to-back slices: minimum 26 cycles per slice, since the handshake cycle returns to LOAD and no bit is accepted during PRESENT.
- out is registered, and it is updated only in LOAD. It may show partial slice contents while outValid=0; consumers must qualify with outValid.
- sliceIdx = sliceCnt, valid in LOAD, PRESENT and DONE. It holds its final value in DONE and is cleared on the next start.
- Boundary conditions:
  - start while busy is ignored.
  - start asserted in the same cycle done pulses is ignored, because the state is DONE, not IDLE.
  - NUM_SLICES=1: one slice, then DONE.
  - sliceCnt never wraps; the DONE transition precedes overflow.
  - outReady asserted outside PRESENT has no effect.
  - serValid and start asserted together in IDLE: that serial bit is not captured (serReady=0 in IDLE).

Decomposition:
- Shared package: WIDTH=25, the state typedef/encoding (IDLE, LOAD, PRESENT, DONE), and the bit-count width constant (5).
- One natural sub-module: bounded_counter (parameterised max, enable, clear, terminal-count flag), instantiated twice: bit counter (max WIDTH-1) and slice counter (max NUM_SLICES-1).
- The shift/placement register and the FSM stay in the top module.

Test Plan:
- Reset mid-LOAD: NUM_SLICES=2, start, feed 10 bits, pulse rst. Required: all outputs 0 immediately (asynchronous), state IDLE, no done. A fresh start then loads normally.
- Single slice with continuous serValid:
  - Stimulus: NUM_SLICES=1, bits 1,0,0,...,0,1 (first and last are 1).
  - Required: outValid rises the cycle after bit 25, with out=25'h1000001 and sliceIdx=0.
  - Then outReady=1 for one cycle gives a done pulse of exactly 1 cycle the following cycle, then busy=0.
- Gapped serial input: serValid toggling 1,0,1,0 while streaming 25'h155AAAA. Required: out=25'h155AAAA on outValid, and serReady=1 throughout LOAD.
- Backpressure: hold outReady=0 for 50 cycles in PRESENT while driving serValid=1 with random serIn. Required: out and outValid stable, serReady=0, no bits absorbed. The next slice starts from bit 0 after the handshake.
- Full run: NUM_SLICES=64, slice k carries pattern k replicated into 25 bits, continuous valid/ready. Required:
  - 64 handshakes with sliceIdx 0..63 in order.
  - done exactly once, 26*64+1 cycles after the start edge ± the handshake alignment checked by the scoreboard.
  - start pulsed mid-run is ignored.
